// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: walks one external full-adder cell across WIDTH
// bits, LSB first, and presents {cout_out, sum_out} with a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] partial_next;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             last_bit;

    // Handshake: start is a request sampled on each rising edge; it is taken
    // only in IDLE or DONE, and done is a one-cycle result-valid strobe.
    assign accept   = start && (state == IDLE || state == DONE);
    assign last_bit = (count == CNT_W'(WIDTH - 1));

    // Written as a shift/or so WIDTH=1 needs no special-case slice.
    assign partial_next = (partial >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    assign busy = (state == RUN);
    assign fa_a = busy & sa[0];
    assign fa_b = busy & sb[0];
    assign fa_c = busy & carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            partial  <= '0;
            carry    <= 1'b0;
            count    <= '0;
            done     <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                sa      <= a_in;
                sb      <= b_in;
                carry   <= cin;
                count   <= '0;
                partial <= '0;
            end else if (state == RUN) begin
                sa      <= sa >> 1;
                sb      <= sb >> 1;
                carry   <= fa_cout;
                partial <= partial_next;
                count   <= count + 1'b1;
                // The final bit goes straight to the result register, so the
                // answer is valid in the same cycle as done.
                if (last_bit) begin
                    sum_out  <= partial_next;
                    cout_out <= fa_cout;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: a WIDTH=8 and a WIDTH=1 instance, each
// driving its own behavioural full-adder cell.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // WIDTH=8 instance
    logic       s8 = 1'b0, c8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       f8a, f8b, f8c, f8s, f8co;
    logic       bz8, d8, co8;
    logic [7:0] so8;

    assign f8s  = f8a ^ f8b ^ f8c;
    assign f8co = (f8a & f8b) | (f8a & f8c) | (f8b & f8c);

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a_in(a8), .b_in(b8), .cin(c8),
        .fa_a(f8a), .fa_b(f8b), .fa_c(f8c), .fa_sum(f8s), .fa_cout(f8co),
        .busy(bz8), .done(d8), .sum_out(so8), .cout_out(co8)
    );

    // WIDTH=1 instance
    logic s1 = 1'b0, c1 = 1'b0;
    logic a1 = 1'b0, b1 = 1'b0;
    logic f1a, f1b, f1c, f1s, f1co;
    logic bz1, d1, co1, so1;

    assign f1s  = f1a ^ f1b ^ f1c;
    assign f1co = (f1a & f1b) | (f1a & f1c) | (f1b & f1c);

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a_in(a1), .b_in(b1), .cin(c1),
        .fa_a(f1a), .fa_b(f1b), .fa_c(f1c), .fa_sum(f1s), .fa_cout(f1co),
        .busy(bz1), .done(d1), .sum_out(so1), .cout_out(co1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One add from start to done; exp is {cout, sum} for the selected width.
    task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [8:0] exp, input string tag);
        int lat;
        int busy_n;
        int want_lat;
        want_lat = w1 ? 1 : 8;
        @(negedge clk);
        if (w1) begin
            s1 = 1'b1; a1 = a[0]; b1 = b[0]; c1 = c;
        end else begin
            s8 = 1'b1; a8 = a; b8 = b; c8 = c;
        end
        @(negedge clk);
        s1 = 1'b0;
        s8 = 1'b0;
        check({tag, "_fa_run"}, 32'(w1 ? {f1a, f1b, f1c} : {f8a, f8b, f8c}),
              32'({a[0], b[0], c}));
        lat = 0;
        busy_n = 0;
        while (!(w1 ? d1 : d8) && lat < 40) begin
            if (w1 ? bz1 : bz8) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(want_lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(want_lat));
        check({tag, "_result"}, w1 ? 32'({co1, so1}) : 32'({co8, so8}), 32'(exp));
        check({tag, "_busy_at_done"}, 32'(w1 ? bz1 : bz8), 32'd0);
        check({tag, "_fa_done"}, 32'(w1 ? {f1a, f1b, f1c} : {f8a, f8b, f8c}), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(w1 ? d1 : d8), 32'd0);
        check({tag, "_held"}, w1 ? 32'({co1, so1}) : 32'({co8, so8}), 32'(exp));
    endtask

    logic [1:0] tt [8];
    int         n;
    int         dn;
    int         gap;
    int         overlap;
    int         first_done;
    int         pos [2];
    logic [7:0] sm [2];

    initial begin
        // {cout, sum} for index {a, b, cin}
        tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bz8), 32'd0);
        check("rst_done", 32'(d8), 32'd0);
        check("rst_sum", 32'({co8, so8}), 32'd0);
        check("rst_fa", 32'({f8a, f8b, f8c}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bz8 | bz1), 32'd0);

        run_op(1'b0, 8'h5A, 8'h3C, 1'b0, 9'h096, "add_5a_3c");
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1, 9'h1FF, "add_ff_ff_c");

        // start and operand changes during RUN must be ignored
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        repeat (2) @(negedge clk);
        s8 = 1'b1; a8 = 8'hAA;
        @(negedge clk);
        s8 = 1'b0; a8 = 8'h55;
        n = 3; dn = 0; first_done = -1;
        while (n < 24) begin
            if (d8) begin
                if (dn == 0) begin
                    first_done = n;
                    sm[0] = so8;
                end
                dn++;
            end
            @(negedge clk);
            n++;
        end
        check("ign_latency", 32'(first_done), 32'd8);
        check("ign_done_count", 32'(dn), 32'd1);
        check("ign_sum", 32'(sm[0]), 32'h30);

        // start held high: back-to-back adds through one DONE cycle
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h01; b8 = 8'h02; c8 = 1'b0;
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04;
        n = 0; dn = 0; gap = 0; overlap = 0;
        pos[0] = 0; pos[1] = 0; sm[0] = '0; sm[1] = '0;
        while (dn < 2 && n < 40) begin
            if (d8) begin
                if (bz8) overlap++;
                pos[dn] = n;
                sm[dn] = so8;
                dn++;
                if (dn == 2) s8 = 1'b0;
            end else if (!bz8) begin
                gap++;
            end
            if (dn < 2) begin
                @(negedge clk);
                n++;
            end
        end
        check("b2b_done_count", 32'(dn), 32'd2);
        check("b2b_first_lat", 32'(pos[0]), 32'd8);
        check("b2b_spacing", 32'(pos[1] - pos[0]), 32'd9);
        check("b2b_sum0", 32'(sm[0]), 32'h03);
        check("b2b_sum1", 32'(sm[1]), 32'h07);
        check("b2b_busy_gap", 32'(gap), 32'd0);
        check("b2b_overlap", 32'(overlap), 32'd0);
        @(negedge clk);
        check("b2b_to_idle", 32'({bz8, d8}), 32'd0);

        // reset mid-RUN aborts without a done pulse
        run_op(1'b0, 8'h11, 8'h22, 1'b0, 9'h033, "add_11_22");
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h40; b8 = 8'h40; c8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", 32'(bz8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bz8), 32'd0);
        check("abort_done", 32'(d8), 32'd0);
        check("abort_result", 32'({co8, so8}), 32'd0);
        check("abort_fa", 32'({f8a, f8b, f8c}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0; gap = 0;
        repeat (20) begin
            @(negedge clk);
            if (d8) dn++;
            if (bz8) gap++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_no_busy", 32'(gap), 32'd0);
        check("abort_sum_kept", 32'({co8, so8}), 32'd0);

        // WIDTH=1 truth table
        run_op(1'b1, 8'h01, 8'h01, 1'b1, 9'h003, "w1_111");
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_op(1'b1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], {7'd0, tt[i]},
                   $sformatf("w1_tt%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
